qspi_req_arb: RTL and testbench

QSPI_REQ_ARB -- requirements
Module: qspi_req_arb

---
 rtl/qspi_req_arb.sv | 173 +++++++++++++++++
 tb/tb_qspi_req_arb.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_req_arb.sv
// rtl/qspi_req_arb.sv - arbiter between instruction-fetch and data ports onto one QSPI read/write interface
module qspi_req_arb #(
  parameter int ARB_MODE = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_adr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_rd_req,
  input  logic        d_wr_req,
  input  logic        d_w,
  input  logic        d_hw,
  input  logic [31:0] d_adr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        q_read_req,
  output logic        q_read_w,
  output logic        q_read_hw,
  output logic [31:0] q_read_adr,
  input  logic        q_read_valid,
  input  logic [31:0] q_read_data,
  output logic        q_write_req,
  output logic        q_write_w,
  output logic        q_write_hw,
  output logic [31:0] q_write_adr,
  output logic [31:0] q_write_data,
  input  logic        q_write_finish,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT_RD = 3'd2,
    WAIT_WR = 3'd3,
    ACK     = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        win_i_q, win_i_d;
  logic        wr_q, wr_d;
  logic        last_i_q, last_i_d;
  logic        w_q, w_d;
  logic        hw_q, hw_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic        d_req;
  logic        grant_i;

  assign d_req = d_rd_req | d_wr_req;

  // Round-robin: on a tie the port that did not win last time goes first.
  always_comb begin
    grant_i = 1'b0;
    if (ARB_MODE == 1) begin
      grant_i = i_req;
    end else begin
      grant_i = i_req & (~d_req | ~last_i_q);
    end
  end

  always_comb begin
    state_d   = state_q;
    win_i_d   = win_i_q;
    wr_d      = wr_q;
    last_i_d  = last_i_q;
    w_d       = w_q;
    hw_d      = hw_q;
    adr_d     = adr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (i_req | d_req) begin
          state_d = ISSUE;
          if (grant_i) begin
            win_i_d  = 1'b1;
            wr_d     = 1'b0;
            w_d      = 1'b1;
            hw_d     = 1'b0;
            adr_d    = i_adr;
            wdata_d  = 32'h0;
            last_i_d = 1'b1;
          end else begin
            // A pending read is served before a simultaneous write.
            win_i_d  = 1'b0;
            wr_d     = ~d_rd_req;
            w_d      = d_w;
            hw_d     = d_hw;
            adr_d    = d_adr;
            wdata_d  = d_wdata;
            last_i_d = 1'b0;
          end
        end
      end
      ISSUE: begin
        state_d = wr_q ? WAIT_WR : WAIT_RD;
      end
      WAIT_RD: begin
        if (q_read_valid) begin
          state_d = ACK;
          if (win_i_q) begin
            i_rdata_d = q_read_data;
          end else begin
            d_rdata_d = q_read_data;
          end
        end
      end
      WAIT_WR: begin
        if (q_write_finish) begin
          state_d = ACK;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      win_i_q   <= 1'b0;
      wr_q      <= 1'b0;
      last_i_q  <= 1'b0;
      w_q       <= 1'b0;
      hw_q      <= 1'b0;
      adr_q     <= 32'h0;
      wdata_q   <= 32'h0;
      i_rdata_q <= 32'h0;
      d_rdata_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      win_i_q   <= win_i_d;
      wr_q      <= wr_d;
      last_i_q  <= last_i_d;
      w_q       <= w_d;
      hw_q      <= hw_d;
      adr_q     <= adr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign q_read_req   = (state_q == ISSUE) & ~wr_q;
  assign q_write_req  = (state_q == ISSUE) & wr_q;
  assign q_read_w     = w_q;
  assign q_read_hw    = hw_q;
  assign q_read_adr   = adr_q;
  assign q_write_w    = w_q;
  assign q_write_hw   = hw_q;
  assign q_write_adr  = adr_q;
  assign q_write_data = wdata_q;

  assign i_ack   = (state_q == ACK) & win_i_q;
  assign d_ack   = (state_q == ACK) & ~win_i_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_qspi_req_arb.sv
// tb/tb_qspi_req_arb.sv - scoreboard bench for qspi_req_arb
module tb_qspi_req_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_adr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_rd_req, d_wr_req, d_w, d_hw;
  logic [31:0] d_adr, d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        q_read_req, q_read_w, q_read_hw;
  logic [31:0] q_read_adr;
  logic        q_read_valid;
  logic [31:0] q_read_data;
  logic        q_write_req, q_write_w, q_write_hw;
  logic [31:0] q_write_adr, q_write_data;
  logic        q_write_finish;
  logic        busy;

  always #5 clk = ~clk;

  qspi_req_arb #(.ARB_MODE(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_adr(i_adr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_rd_req(d_rd_req), .d_wr_req(d_wr_req), .d_w(d_w), .d_hw(d_hw),
    .d_adr(d_adr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .q_read_req(q_read_req), .q_read_w(q_read_w), .q_read_hw(q_read_hw),
    .q_read_adr(q_read_adr), .q_read_valid(q_read_valid), .q_read_data(q_read_data),
    .q_write_req(q_write_req), .q_write_w(q_write_w), .q_write_hw(q_write_hw),
    .q_write_adr(q_write_adr), .q_write_data(q_write_data),
    .q_write_finish(q_write_finish), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int done_cyc = -10;
  bit prev_req = 1'b0;
  bit slave_en = 1'b1;
  bit spur_req = 1'b0;

  logic [32:0] ack_exp_q[$];    // {is_instr, rdata}
  logic [66:0] req_exp_q[$];    // {is_write, w, hw, adr, wdata}
  logic [31:0] slave_data_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops expectations whenever the DUT presents a request or an ack.
  initial begin
    logic [32:0] ack_act, ack_exp;
    logic [66:0] req_act, req_exp;
    forever begin
      @(negedge clk);
      if (q_read_valid || q_write_finish) done_cyc = cyc;
      if (i_ack || d_ack) begin
        n_tests++;
        ack_act = {i_ack, i_ack ? i_rdata : d_rdata};
        if (ack_exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_ack got=%h", ack_act);
        end else begin
          ack_exp = ack_exp_q.pop_front();
          if (ack_act !== ack_exp || (i_ack && d_ack)) begin
            n_fail++;
            $display("FAIL ack got=%h exp=%h (i_ack=%0b d_ack=%0b)", ack_act, ack_exp, i_ack, d_ack);
          end
        end
        n_tests++;
        if (cyc - done_cyc != 1) begin
          n_fail++;
          $display("FAIL ack_latency got=%0d exp=1", cyc - done_cyc);
        end
      end
      if (q_read_req || q_write_req) begin
        n_tests++;
        if (q_write_req)
          req_act = {1'b1, q_write_w, q_write_hw, q_write_adr, q_write_data};
        else
          req_act = {1'b0, q_read_w, q_read_hw, q_read_adr, 32'h0};
        if (req_exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_qreq got=%h", req_act);
        end else begin
          req_exp = req_exp_q.pop_front();
          if (req_act !== req_exp || (q_read_req && q_write_req)) begin
            n_fail++;
            $display("FAIL qreq got=%h exp=%h", req_act, req_exp);
          end
        end
        n_tests++;
        if (prev_req) begin
          n_fail++;
          $display("FAIL qreq_pulse_width got=2+ cycles exp=1");
        end
      end
      prev_req = q_read_req | q_write_req;
    end
  end

  // QSPI interface model: completes each request two cycles after it is seen.
  initial begin
    q_read_valid = 1'b0;
    q_read_data = 32'h0;
    q_write_finish = 1'b0;
    forever begin
      @(negedge clk);
      if (slave_en && q_read_req) begin
        repeat (2) @(posedge clk);
        #1;
        q_read_data = (slave_data_q.size() != 0) ? slave_data_q.pop_front() : 32'hDEAD_DEAD;
        q_read_valid = 1'b1;
        @(posedge clk);
        #1 q_read_valid = 1'b0;
      end else if (slave_en && q_write_req) begin
        repeat (2) @(posedge clk);
        #1 q_write_finish = 1'b1;
        @(posedge clk);
        #1 q_write_finish = 1'b0;
      end else if (spur_req) begin
        spur_req = 1'b0;
        #1;
        q_read_data = 32'hFFFF_0000;
        q_read_valid = 1'b1;
        q_write_finish = 1'b1;
        @(posedge clk);
        #1;
        q_read_valid = 1'b0;
        q_write_finish = 1'b0;
      end
    end
  end

  task automatic wait_ack(input bit is_i);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(is_i ? i_ack : d_ack) && n < 200);
    if (!(is_i ? i_ack : d_ack)) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_ack_timeout got=no ack exp=ack within 200 cycles", is_i ? "i" : "d");
    end
  endtask

  task automatic i_txn(input logic [31:0] adr);
    i_adr = adr;
    i_req = 1'b1;
    wait_ack(1'b1);
    @(posedge clk);
    #1 i_req = 1'b0;
  endtask

  task automatic d_txn(input bit rd, input bit wr, input bit w, input bit hw,
                       input logic [31:0] adr, input logic [31:0] wdata);
    d_rd_req = rd;
    d_wr_req = wr;
    d_w = w;
    d_hw = hw;
    d_adr = adr;
    d_wdata = wdata;
    wait_ack(1'b0);
    @(posedge clk);
    #1;
    d_rd_req = 1'b0;
    d_wr_req = 1'b0;
  endtask

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    i_req = 1'b0; i_adr = 32'h0;
    d_rd_req = 1'b0; d_wr_req = 1'b0; d_w = 1'b0; d_hw = 1'b0;
    d_adr = 32'h0; d_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          {i_ack, i_rdata, d_ack, d_rdata, q_read_req, q_read_w, q_read_hw, q_read_adr,
           q_write_req, q_write_w, q_write_hw, q_write_adr, q_write_data, busy}, '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single instruction fetch
    req_exp_q.push_back({1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0});
    slave_data_q.push_back(32'h1234_5678);
    ack_exp_q.push_back({1'b1, 32'h1234_5678});
    i_txn(32'h0000_0100);

    // Byte write leaves d_rdata at its reset value
    req_exp_q.push_back({1'b1, 1'b0, 1'b0, 32'h0200_0003, 32'h0000_00A5});
    ack_exp_q.push_back({1'b0, 32'h0});
    d_txn(1'b0, 1'b1, 1'b0, 1'b0, 32'h0200_0003, 32'h0000_00A5);

    // Word read, halfword write (rdata held), byte read
    req_exp_q.push_back({1'b0, 1'b1, 1'b0, 32'h0200_0010, 32'h0});
    slave_data_q.push_back(32'hCAFE_F00D);
    ack_exp_q.push_back({1'b0, 32'hCAFE_F00D});
    d_txn(1'b1, 1'b0, 1'b1, 1'b0, 32'h0200_0010, 32'h0);

    req_exp_q.push_back({1'b1, 1'b0, 1'b1, 32'h0200_0022, 32'h0000_BEEF});
    ack_exp_q.push_back({1'b0, 32'hCAFE_F00D});
    d_txn(1'b0, 1'b1, 1'b0, 1'b1, 32'h0200_0022, 32'h0000_BEEF);

    req_exp_q.push_back({1'b0, 1'b0, 1'b0, 32'h0200_0031, 32'h0});
    slave_data_q.push_back(32'h0000_005A);
    ack_exp_q.push_back({1'b0, 32'h0000_005A});
    d_txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h0200_0031, 32'h0);

    // Read and write together: read first, then the write
    req_exp_q.push_back({1'b0, 1'b1, 1'b0, 32'h0200_0040, 32'h0});
    req_exp_q.push_back({1'b1, 1'b1, 1'b0, 32'h0200_0040, 32'h55AA_55AA});
    slave_data_q.push_back(32'h0BAD_BEEF);
    ack_exp_q.push_back({1'b0, 32'h0BAD_BEEF});
    ack_exp_q.push_back({1'b0, 32'h0BAD_BEEF});
    d_w = 1'b1; d_hw = 1'b0; d_adr = 32'h0200_0040; d_wdata = 32'h55AA_55AA;
    d_rd_req = 1'b1; d_wr_req = 1'b1;
    wait_ack(1'b0);
    @(posedge clk);
    #1 d_rd_req = 1'b0;
    wait_ack(1'b0);
    @(posedge clk);
    #1 d_wr_req = 1'b0;
    check("i_rdata_held", i_rdata, 32'h1234_5678);

    // Spurious completions while idle
    repeat (2) @(posedge clk);
    #1 spur_req = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("spurious_no_effect", {busy, i_rdata, d_rdata}, {1'b0, 32'h1234_5678, 32'h0BAD_BEEF});

    // Reset while waiting for read data
    slave_en = 1'b0;
    req_exp_q.push_back({1'b0, 1'b1, 1'b0, 32'h0000_0400, 32'h0});
    i_adr = 32'h0000_0400;
    i_req = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!q_read_req && n < 50);
    check("midreset_issue_seen", q_read_req, 1'b1);
    @(posedge clk);
    #1;
    check("midreset_in_wait", busy, 1'b1);
    rst_n = 1'b0;
    i_req = 1'b0;
    #1;
    check("midreset_cleared", {busy, i_rdata, d_rdata}, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    slave_en = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("midreset_idle", busy, 1'b0);

    // Ties out of reset: instruction first, then data wins the repeat tie
    req_exp_q.push_back({1'b0, 1'b1, 1'b0, 32'h0000_0200, 32'h0});
    req_exp_q.push_back({1'b0, 1'b1, 1'b0, 32'h0000_0300, 32'h0});
    req_exp_q.push_back({1'b0, 1'b1, 1'b0, 32'h0000_0204, 32'h0});
    slave_data_q.push_back(32'h1111_1111);
    slave_data_q.push_back(32'h2222_2222);
    slave_data_q.push_back(32'h3333_3333);
    ack_exp_q.push_back({1'b1, 32'h1111_1111});
    ack_exp_q.push_back({1'b0, 32'h2222_2222});
    ack_exp_q.push_back({1'b1, 32'h3333_3333});
    fork
      begin
        i_txn(32'h0000_0200);
        i_txn(32'h0000_0204);
      end
      begin
        d_txn(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0300, 32'h0);
      end
    join

    repeat (5) @(posedge clk);
    #1;
    check("ack_queue_drained", ack_exp_q.size(), 0);
    check("req_queue_drained", req_exp_q.size(), 0);
    check("final_rdata", {i_rdata, d_rdata}, {32'h3333_3333, 32'h2222_2222});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
